// File: rtl/up_pkg.sv
// Shared state encoding, control-word layout and opcode map for the 4-bit uP
// control sequencer.
package up_pkg;

  localparam int unsigned SIG_W  = 13;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned ALU_W  = 3;
  localparam int unsigned WAIT_W = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WAIT  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // Bit positions inside the 13-bit control word
  localparam int unsigned SIG_LOAD_OUT   = 0;
  localparam int unsigned SIG_OE_OPRND   = 1;
  localparam int unsigned SIG_OE_IN      = 2;
  localparam int unsigned SIG_OE_ALU     = 3;
  localparam int unsigned SIG_WE_RAM     = 4;
  localparam int unsigned SIG_CS_RAM     = 5;
  localparam int unsigned SIG_S_LO       = 6;
  localparam int unsigned SIG_S_HI       = 8;
  localparam int unsigned SIG_LOAD_FLAGS = 9;
  localparam int unsigned SIG_LOAD_A     = 10;
  localparam int unsigned SIG_LOAD_PC    = 11;
  localparam int unsigned SIG_INC_PC     = 12;

  localparam logic [SIG_W-1:0] FETCH_WORD = 13'h1000;
  localparam logic [SIG_W-1:0] LOAD_MASK  = 13'h1E11;

  localparam logic [OP_W-1:0] OP_NOP  = 4'h0;
  localparam logic [OP_W-1:0] OP_LDI  = 4'h1;
  localparam logic [OP_W-1:0] OP_LDM  = 4'h2;
  localparam logic [OP_W-1:0] OP_STM  = 4'h3;
  localparam logic [OP_W-1:0] OP_ADD  = 4'h4;
  localparam logic [OP_W-1:0] OP_SUB  = 4'h5;
  localparam logic [OP_W-1:0] OP_AND  = 4'h6;
  localparam logic [OP_W-1:0] OP_OR   = 4'h7;
  localparam logic [OP_W-1:0] OP_XOR  = 4'h8;
  localparam logic [OP_W-1:0] OP_ADDM = 4'h9;
  localparam logic [OP_W-1:0] OP_IN   = 4'hA;
  localparam logic [OP_W-1:0] OP_OUT  = 4'hB;
  localparam logic [OP_W-1:0] OP_JMP  = 4'hC;
  localparam logic [OP_W-1:0] OP_JC   = 4'hD;
  localparam logic [OP_W-1:0] OP_JZ   = 4'hE;
  localparam logic [OP_W-1:0] OP_JNZ  = 4'hF;

  localparam logic [ALU_W-1:0] ALU_PASS = 3'd0;
  localparam logic [ALU_W-1:0] ALU_ADD  = 3'd1;
  localparam logic [ALU_W-1:0] ALU_SUB  = 3'd2;
  localparam logic [ALU_W-1:0] ALU_AND  = 3'd3;
  localparam logic [ALU_W-1:0] ALU_OR   = 3'd4;
  localparam logic [ALU_W-1:0] ALU_XOR  = 3'd5;

  // Exec word with every load strobe and the RAM write held off
  function automatic logic [SIG_W-1:0] hold_word(input logic [SIG_W-1:0] word);
    return word & ~LOAD_MASK;
  endfunction

endpackage

// File: rtl/up_decode_rom.sv
// Combinational decode table: opcode plus flags to the 13-bit exec control word.
module up_decode_rom
  import up_pkg::*;
(
  input  logic [OP_W-1:0]  i_instr,
  input  logic             i_c_flag,
  input  logic             i_z_flag,
  output logic [SIG_W-1:0] o_word
);

  logic [SIG_W-1:0] w_word;
  logic             w_take;

  always_comb begin
    w_word = '0;
    w_take = 1'b0;
    case (i_instr)
      OP_LDI: begin
        w_word[SIG_OE_OPRND] = 1'b1;
        w_word[SIG_LOAD_A]   = 1'b1;
      end
      OP_LDM: begin
        w_word[SIG_CS_RAM] = 1'b1;
        w_word[SIG_LOAD_A] = 1'b1;
      end
      OP_STM: begin
        w_word[SIG_OE_ALU]         = 1'b1;
        w_word[SIG_WE_RAM]         = 1'b1;
        w_word[SIG_CS_RAM]         = 1'b1;
        w_word[SIG_S_HI:SIG_S_LO]  = ALU_PASS;
      end
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        w_word[SIG_OE_OPRND]   = 1'b1;
        w_word[SIG_LOAD_FLAGS] = 1'b1;
        w_word[SIG_LOAD_A]     = 1'b1;
        case (i_instr)
          OP_ADD:  w_word[SIG_S_HI:SIG_S_LO] = ALU_ADD;
          OP_SUB:  w_word[SIG_S_HI:SIG_S_LO] = ALU_SUB;
          OP_AND:  w_word[SIG_S_HI:SIG_S_LO] = ALU_AND;
          OP_OR:   w_word[SIG_S_HI:SIG_S_LO] = ALU_OR;
          default: w_word[SIG_S_HI:SIG_S_LO] = ALU_XOR;
        endcase
      end
      OP_ADDM: begin
        w_word[SIG_CS_RAM]        = 1'b1;
        w_word[SIG_S_HI:SIG_S_LO] = ALU_ADD;
        w_word[SIG_LOAD_FLAGS]    = 1'b1;
        w_word[SIG_LOAD_A]        = 1'b1;
      end
      OP_IN: begin
        w_word[SIG_OE_IN]  = 1'b1;
        w_word[SIG_LOAD_A] = 1'b1;
      end
      OP_OUT: begin
        w_word[SIG_OE_ALU]        = 1'b1;
        w_word[SIG_S_HI:SIG_S_LO] = ALU_PASS;
        w_word[SIG_LOAD_OUT]      = 1'b1;
      end
      OP_JMP:  w_take = 1'b1;
      OP_JC:   w_take = i_c_flag;
      OP_JZ:   w_take = i_z_flag;
      OP_JNZ:  w_take = ~i_z_flag;
      default: ;
    endcase
    // A taken jump loads the operand into the PC; an untaken one is a no-op
    if (w_take) begin
      w_word[SIG_OE_OPRND] = 1'b1;
      w_word[SIG_LOAD_PC]  = 1'b1;
    end
  end

  assign o_word = w_word;

endmodule

// File: rtl/up_sequencer.sv
// Multi-cycle fetch/exec control sequencer with RAM wait states, run/halt,
// single-step and a retired-instruction counter.
module up_sequencer
  import up_pkg::*;
#(
  parameter int unsigned RAM_WAIT     = 3,
  parameter bit          RUN_AT_RESET = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [OP_W-1:0]  instr,
  input  logic             c_flag,
  input  logic             z_flag,
  input  logic             run,
  input  logic             step,
  output logic [SIG_W-1:0] signals,
  output logic             phase,
  output logic             halted,
  output logic             mem_busy,
  output logic [CNT_W-1:0] retired
);

  state_t              r_state;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic                r_step_q;
  logic [CNT_W-1:0]    r_retired;

  state_t              w_state_nxt;
  state_t              w_done_state;
  logic [WAIT_W-1:0]   w_wait_nxt;
  logic                w_retire;
  logic [SIG_W-1:0]    w_exec_word;
  logic [SIG_W-1:0]    w_sig;
  logic                w_phase;
  logic                w_halted;
  logic                w_busy;
  logic                w_step_rise;

  up_decode_rom u_decode (
    .i_instr  (instr),
    .i_c_flag (c_flag),
    .i_z_flag (z_flag),
    .o_word   (w_exec_word)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
      r_step_q   <= 1'b0;
      r_retired  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      r_step_q   <= step;
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign w_step_rise  = step & ~r_step_q;
  assign w_done_state = run ? S_FETCH : S_HALT;

  // Next state and control word; loads only appear on an instruction's last exec cycle
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_retire    = 1'b0;
    w_sig       = '0;
    w_phase     = 1'b0;
    w_halted    = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = RUN_AT_RESET ? S_FETCH : S_HALT;
      end
      S_FETCH: begin
        w_sig       = FETCH_WORD;
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
        w_phase = 1'b1;
        if (w_exec_word[SIG_CS_RAM] && (RAM_WAIT != 0)) begin
          w_sig       = hold_word(w_exec_word);
          w_wait_nxt  = WAIT_W'(RAM_WAIT - 1);
          w_state_nxt = S_WAIT;
        end else begin
          w_sig       = w_exec_word;
          w_retire    = 1'b1;
          w_state_nxt = w_done_state;
        end
      end
      S_WAIT: begin
        w_phase = 1'b1;
        w_busy  = 1'b1;
        if (r_wait_cnt != '0) begin
          w_sig      = hold_word(w_exec_word);
          w_wait_nxt = r_wait_cnt - WAIT_W'(1);
        end else begin
          w_sig       = w_exec_word;
          w_retire    = 1'b1;
          w_state_nxt = w_done_state;
        end
      end
      S_HALT: begin
        w_halted = 1'b1;
        if (run || w_step_rise) begin
          w_state_nxt = S_FETCH;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Reset forces every output low without waiting for a clock edge
  assign signals  = reset ? '0 : w_sig;
  assign phase    = reset ? 1'b0 : w_phase;
  assign halted   = reset ? 1'b0 : w_halted;
  assign mem_busy = reset ? 1'b0 : w_busy;
  assign retired  = r_retired;

endmodule

// File: tb/tb_up_sequencer.sv
// Scoreboard bench for up_sequencer: three parameterisations share one random
// stimulus stream and are checked cycle by cycle against an instruction-level model.
module tb_up_sequencer;

  localparam int ND     = 3;
  localparam int M_IDLE = 0;
  localparam int M_HALT = 1;
  localparam int M_BUSY = 2;
  localparam logic [12:0] T_FETCH = 13'h1000;
  localparam logic [12:0] T_MASK  = 13'h1E11;

  typedef struct packed {
    logic [12:0] sig;
    logic        ph;
    logic        hl;
    logic        mb;
    logic [15:0] ret;
  } exp_t;

  logic        clock;
  logic        reset, run, step, c_flag, z_flag;
  logic [3:0]  instr;
  logic [12:0] a_sig [ND];
  logic        a_ph  [ND];
  logic        a_hl  [ND];
  logic        a_mb  [ND];
  logic [15:0] a_ret [ND];
  logic [15:0] ret0;
  logic [3:0]  ret1;
  logic [7:0]  ret2;

  exp_t        sb_q[$];
  int          n_chk, n_err;

  int          md  [ND];
  int          pos [ND];
  int          len [ND];
  int unsigned cnt [ND];
  logic        sp;

  up_sequencer #(.RAM_WAIT(3), .RUN_AT_RESET(1'b1), .CNT_W(16)) u_dut0 (
    .clock(clock), .reset(reset), .instr(instr), .c_flag(c_flag), .z_flag(z_flag),
    .run(run), .step(step), .signals(a_sig[0]), .phase(a_ph[0]), .halted(a_hl[0]),
    .mem_busy(a_mb[0]), .retired(ret0));
  up_sequencer #(.RAM_WAIT(0), .RUN_AT_RESET(1'b1), .CNT_W(4)) u_dut1 (
    .clock(clock), .reset(reset), .instr(instr), .c_flag(c_flag), .z_flag(z_flag),
    .run(run), .step(step), .signals(a_sig[1]), .phase(a_ph[1]), .halted(a_hl[1]),
    .mem_busy(a_mb[1]), .retired(ret1));
  up_sequencer #(.RAM_WAIT(7), .RUN_AT_RESET(1'b0), .CNT_W(8)) u_dut2 (
    .clock(clock), .reset(reset), .instr(instr), .c_flag(c_flag), .z_flag(z_flag),
    .run(run), .step(step), .signals(a_sig[2]), .phase(a_ph[2]), .halted(a_hl[2]),
    .mem_busy(a_mb[2]), .retired(ret2));

  assign a_ret[0] = ret0;
  assign a_ret[1] = 16'(ret1);
  assign a_ret[2] = 16'(ret2);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int p_wait(input int d);
    case (d)
      0:       return 3;
      1:       return 0;
      default: return 7;
    endcase
  endfunction

  function automatic bit p_run(input int d);
    return d != 2;
  endfunction

  function automatic int p_cw(input int d);
    case (d)
      0:       return 16;
      1:       return 4;
      default: return 8;
    endcase
  endfunction

  // Instruction set as documented: one exec word per opcode
  function automatic logic [12:0] tb_word(input logic [3:0] op, input logic c, input logic z);
    case (op)
      4'h1:    return 13'h0402;
      4'h2:    return 13'h0420;
      4'h3:    return 13'h0038;
      4'h4:    return 13'h0642;
      4'h5:    return 13'h0682;
      4'h6:    return 13'h06C2;
      4'h7:    return 13'h0702;
      4'h8:    return 13'h0742;
      4'h9:    return 13'h0660;
      4'hA:    return 13'h0404;
      4'hB:    return 13'h0009;
      4'hC:    return 13'h0802;
      4'hD:    return c ? 13'h0802 : 13'h0000;
      4'hE:    return z ? 13'h0802 : 13'h0000;
      4'hF:    return z ? 13'h0000 : 13'h0802;
      default: return 13'h0000;
    endcase
  endfunction

  task automatic chk(input string nm, input int d, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, d, $time, act, exp);
    end
  endtask

  // Advance each model across one clock edge using the inputs held during the cycle
  task automatic model_edge();
    logic e;
    if (reset) begin
      for (int d = 0; d < ND; d++) begin
        md[d] = M_IDLE; pos[d] = 0; cnt[d] = 0;
      end
      sp = 1'b0;
    end else begin
      e  = step && !sp;
      sp = step;
      for (int d = 0; d < ND; d++) begin
        case (md[d])
          M_IDLE: begin md[d] = p_run(d) ? M_BUSY : M_HALT; pos[d] = 0; end
          M_HALT: if (run || e) begin md[d] = M_BUSY; pos[d] = 0; end
          default: begin
            if (pos[d] == 0) pos[d] = 1;
            else if (pos[d] < len[d]) pos[d]++;
            else begin
              cnt[d] = (cnt[d] + 1) % (32'd1 << p_cw(d));
              if (run) pos[d] = 0;
              else md[d] = M_HALT;
            end
          end
        endcase
      end
    end
  endtask

  task automatic model_push();
    exp_t e;
    logic [12:0] w;
    for (int d = 0; d < ND; d++) begin
      e = '0;
      if (!reset) begin
        case (md[d])
          M_HALT: e.hl = 1'b1;
          M_BUSY: begin
            if (pos[d] == 0) e.sig = T_FETCH;
            else begin
              w = tb_word(instr, c_flag, z_flag);
              if (pos[d] == 1) len[d] = (w[5] && p_wait(d) > 0) ? 1 + p_wait(d) : 1;
              e.sig = (pos[d] < len[d]) ? (w & ~T_MASK) : w;
              e.ph  = 1'b1;
              e.mb  = (pos[d] >= 2);
            end
          end
          default: ;
        endcase
        e.ret = 16'(cnt[d]);
      end
      sb_q.push_back(e);
    end
  endtask

  // One clock: model crosses the edge, then new inputs and expectations for this cycle
  task automatic tick(input logic rst, input logic r, input logic s, input int op);
    @(posedge clock);
    model_edge();
    #2;
    reset  = rst;
    run    = r;
    step   = s;
    instr  = (op >= 0) ? 4'(op) : 4'($urandom_range(0, 15));
    c_flag = 1'($urandom_range(0, 1));
    z_flag = 1'($urandom_range(0, 1));
    model_push();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() >= ND) begin
        for (int d = 0; d < ND; d++) begin
          e = sb_q.pop_front();
          chk("signals",  d, 16'(a_sig[d]), 16'(e.sig));
          chk("phase",    d, 16'(a_ph[d]),  16'(e.ph));
          chk("halted",   d, 16'(a_hl[d]),  16'(e.hl));
          chk("mem_busy", d, 16'(a_mb[d]),  16'(e.mb));
          chk("retired",  d, a_ret[d],      e.ret);
        end
      end
    end
  end

  initial begin : stim
    logic [15:0] r_before;
    bit          found;
    logic        rr, rst;
    n_chk = 0; n_err = 0; sp = 1'b0;
    for (int d = 0; d < ND; d++) begin md[d] = M_IDLE; pos[d] = 0; len[d] = 1; cnt[d] = 0; end
    reset = 1'b1; run = 1'b1; step = 1'b0; instr = 4'h0; c_flag = 1'b0; z_flag = 1'b0;

    tick(1, 1, 0, 0);
    tick(1, 1, 0, 0);
    // Free run with non-RAM opcodes, then RAM loads that stretch into wait states
    repeat (16) tick(0, 1, 0, 4);
    repeat (16) tick(0, 1, 0, 2);
    repeat (8)  tick(0, 1, 0, -1);

    // Drop run during dut0's exec cycle; the instruction finishes, then it halts
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick(0, 1, 0, 1);
      if (md[0] == M_BUSY && pos[0] == 0) found = 1;
    end
    n_chk++;
    if (!found) begin n_err++; $display("FAIL reach_fetch dut0 got=none want=fetch"); end
    tick(0, 0, 0, 1);
    repeat (10) tick(0, 0, 0, -1);
    @(negedge clock); #1;
    chk("halted_before_step", 0, 16'(a_hl[0]), 16'd1);
    r_before = a_ret[0];
    tick(0, 0, 1, 1);
    repeat (12) tick(0, 0, 1, 1);
    repeat (3)  tick(0, 0, 0, 1);
    @(negedge clock); #1;
    chk("step_retires_one", 0, 16'(a_ret[0] - r_before), 16'd1);
    chk("halted_after_step", 0, 16'(a_hl[0]), 16'd1);

    // Run and step rise together while halted: free-run resumes
    tick(0, 1, 1, 1);
    repeat (12) tick(0, 1, 0, 4);
    @(negedge clock); #1;
    chk("free_run_after_both", 0, 16'(a_hl[0]), 16'd0);

    // Async reset landing in dut0's wait state with one hold cycle left
    found = 0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick(0, 1, 0, 2);
      if (md[0] == M_BUSY && pos[0] == 3) found = 1;
    end
    n_chk++;
    if (!found) begin n_err++; $display("FAIL reach_wait dut0 got=none want=wait_cnt1"); end
    @(negedge clock); #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < ND; d++) begin
      chk("rst_signals",  d, 16'(a_sig[d]), 16'd0);
      chk("rst_phase",    d, 16'(a_ph[d]),  16'd0);
      chk("rst_mem_busy", d, 16'(a_mb[d]),  16'd0);
      chk("rst_retired",  d, a_ret[d],      16'd0);
    end
    tick(1, 1, 0, 2);
    tick(0, 1, 0, 2);
    repeat (6) tick(0, 1, 0, 2);

    // Random traffic: run toggles, step pulses, occasional reset
    rr = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) rr = ~rr;
      rst = ($urandom_range(0, 299) == 0);
      tick(rst, rr, 1'($urandom_range(0, 3) == 0), -1);
    end
    tick(0, 1, 0, -1);
    @(negedge clock); #1;
    chk("scoreboard_drained", 0, 16'(sb_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
